// File: rtl/crc_pkg.sv
// crc_pkg: CRC-8 constants and FSM encoding shared by the generator and receiver ends
package crc_pkg;
  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] DEF_POLY = 8'h07;
  localparam logic [CRC_W-1:0] DEF_INIT = 8'h00;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
endpackage

// File: rtl/crc8_byte_step.sv
// crc8_byte_step: one byte of MSB-first CRC-8, purely combinational
module crc8_byte_step
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEF_POLY
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       byte_in,
  output logic [CRC_W-1:0] crc_out
);
  logic [CRC_W-1:0] c;
  always_comb begin
    c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) c = c[CRC_W-1] ? ((c << 1) ^ POLY) : (c << 1);
    crc_out = c;
  end
endmodule

// File: rtl/crc_frame_receiver.sv
// crc_frame_receiver: strips and checks the trailing CRC-8 byte of each frame
module crc_frame_receiver
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY    = DEF_POLY,
  parameter logic [CRC_W-1:0] INIT    = DEF_INIT,
  parameter int               MAX_LEN = 64,
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [7:0]       data_in,
  input  logic             data_last,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             frame_done,
  output logic             crc_error,
  output logic             len_error,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] error_count
);
  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  logic [0:0]       state;
  logic [7:0]       hold;
  logic [CRC_W-1:0] crc_reg, crc_nxt;
  logic [LEN_W-1:0] len_cnt;
  logic             held, fin, crc_bad, len_bad;
  crc8_byte_step #(.POLY(POLY)) u_step (.crc_in(crc_reg), .byte_in(hold), .crc_out(crc_nxt));
  // A byte is only known to be payload once its successor arrives, so the check
  // on the CRC byte folds in the still-held final payload byte.
  assign held    = (state == ST_HOLD);
  assign fin     = data_valid & data_last;
  assign crc_bad = held ? (crc_nxt != data_in) : (INIT != data_in);
  assign len_bad = held && (len_cnt >= LEN_MAX);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      hold        <= '0;
      crc_reg     <= INIT;
      len_cnt     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      frame_done  <= 1'b0;
      crc_error   <= 1'b0;
      len_error   <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      out_valid  <= data_valid & held;
      out_last   <= fin & held;
      frame_done <= fin;
      crc_error  <= fin & crc_bad;
      len_error  <= fin & len_bad;
      if (fin && ~&frame_count) frame_count <= frame_count + 1'b1;
      if (fin && (crc_bad || len_bad) && ~&error_count) error_count <= error_count + 1'b1;
      if (data_valid) begin
        if (held) out_data <= hold;
        if (fin) begin
          crc_reg <= INIT;
          len_cnt <= '0;
          state   <= ST_IDLE;
        end else begin
          hold  <= data_in;
          state <= ST_HOLD;
          if (held) begin
            crc_reg <= crc_nxt;
            if (len_cnt <= LEN_MAX) len_cnt <= len_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_crc_frame_receiver.sv
// tb_crc_frame_receiver: scenario tasks against a whole-message bit-serial CRC model
module tb_crc_frame_receiver;
  localparam int MAX_LEN = 64;
  localparam int CNT_W = 16;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, reset = 0, data_valid = 0, data_last = 0;
  logic [7:0] data_in = 0;
  logic out_valid, out_last, frame_done, crc_error, len_error;
  logic [7:0] out_data;
  logic [CNT_W-1:0] frame_count, error_count;
  int checks = 0, errors = 0, cyc = 0, fc = 0, ec = 0;
  logic [8:0] got_b[$], exp_b[$];
  logic [1:0] got_d[$], exp_d[$];
  int done_cyc[$];

  crc_frame_receiver #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in), .data_last(data_last),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .frame_done(frame_done),
    .crc_error(crc_error), .len_error(len_error), .frame_count(frame_count), .error_count(error_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) got_b.push_back({out_last, out_data});
    if (frame_done) begin
      got_d.push_back({crc_error, len_error});
      done_cyc.push_back(cyc);
    end else begin
      checks++;
      if (crc_error || len_error) begin
        errors++;
        $display("FAIL flags_without_done crc_error=%b len_error=%b want 0 0", crc_error, len_error);
      end
    end
  end

  // CRC as polynomial division over the message bitstream, MSB first
  function automatic logic [7:0] crc_ref(bq_t p);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    foreach (p[i])
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ p[i][k];
        c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return c;
  endfunction

  task automatic clear_q();
    got_b.delete(); exp_b.delete(); got_d.delete(); exp_d.delete(); done_cyc.delete();
  endtask

  task automatic expect_frame(bq_t p, logic [7:0] crc);
    logic bad, lb;
    foreach (p[i]) exp_b.push_back({i == p.size() - 1, p[i]});
    bad = (crc_ref(p) != crc);
    lb = (p.size() > MAX_LEN);
    exp_d.push_back({bad, lb});
    fc++;
    if (bad || lb) ec++;
  endtask

  task automatic send(logic [7:0] b, logic l);
    data_valid = 1; data_in = b; data_last = l;
    @(posedge clk); #1;
    data_valid = 0; data_last = 0;
  endtask

  task automatic send_frame(bq_t p, logic [7:0] crc);
    foreach (p[i]) send(p[i], 1'b0);
    send(crc, 1'b1);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_last, frame_done, crc_error, len_error, frame_count, error_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {out_valid, out_data, out_last, frame_done, crc_error, len_error, frame_count, error_count});
    end
    @(posedge clk); #1 reset = 1;
    idle(2);
    checks++;
    if (out_valid !== 0 || frame_done !== 0 || frame_count !== 0) begin
      errors++;
      $display("FAIL post_reset_idle out_valid=%b frame_done=%b frame_count=%0d want 0", out_valid, frame_done, frame_count);
    end
  endtask

  task automatic test_check_value(logic [7:0] crc);
    bq_t p;
    int n;
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    clear_q();
    expect_frame(p, crc);
    send_frame(p, crc);
    idle(3);
    n = (got_b.size() != exp_b.size()) ? 1 : 0;
    foreach (exp_b[i]) if (i < got_b.size() && got_b[i] !== exp_b[i]) n++;
    checks++;
    if (n) begin errors++; $display("FAIL check_value_stream crc=%h got %p want %p", crc, got_b, exp_b); end
    checks++;
    if (got_d.size() != 1 || got_d[0] !== exp_d[0]) begin errors++; $display("FAIL check_value_done crc=%h got %p want %p", crc, got_d, exp_d); end
    checks++;
    if (frame_count !== CNT_W'(fc) || error_count !== CNT_W'(ec)) begin
      errors++; $display("FAIL check_value_counts got %0d/%0d want %0d/%0d", frame_count, error_count, fc, ec);
    end
  endtask

  task automatic test_empty();
    bq_t p;
    p.delete();
    clear_q();
    expect_frame(p, 8'h00);
    expect_frame(p, 8'h01);
    send_frame(p, 8'h00);
    idle(2);
    send_frame(p, 8'h01);
    idle(3);
    checks++;
    if (got_b.size() != 0) begin errors++; $display("FAIL empty_no_output got %0d bytes want 0", got_b.size()); end
    checks++;
    if (got_d.size() != 2 || got_d[0] !== exp_d[0] || got_d[1] !== exp_d[1]) begin
      errors++; $display("FAIL empty_done got %p want %p", got_d, exp_d);
    end
    checks++;
    if (frame_count !== CNT_W'(fc) || error_count !== CNT_W'(ec)) begin
      errors++; $display("FAIL empty_counts got %0d/%0d want %0d/%0d", frame_count, error_count, fc, ec);
    end
  endtask

  task automatic test_back_to_back();
    bq_t p;
    p = '{8'h01};
    clear_q();
    expect_frame(p, 8'h07);
    expect_frame(p, 8'h07);
    send_frame(p, 8'h07);
    send_frame(p, 8'h07);
    idle(3);
    checks++;
    if (got_b.size() != 2 || got_b[0] !== 9'h101 || got_b[1] !== 9'h101) begin
      errors++; $display("FAIL b2b_stream got %p want %p", got_b, exp_b);
    end
    checks++;
    if (got_d.size() != 2 || got_d[0] !== 2'b00 || got_d[1] !== 2'b00) begin
      errors++; $display("FAIL b2b_done got %p want %p", got_d, exp_d);
    end
    checks++;
    if (done_cyc.size() != 2 || done_cyc[1] - done_cyc[0] != 2) begin
      errors++; $display("FAIL b2b_spacing got %p want spacing 2", done_cyc);
    end
  endtask

  task automatic test_oversize();
    bq_t p;
    int n;
    repeat (MAX_LEN + 1) p.push_back(8'($urandom));
    clear_q();
    expect_frame(p, crc_ref(p));
    send_frame(p, crc_ref(p));
    idle(3);
    n = (got_b.size() != exp_b.size()) ? 1 : 0;
    foreach (exp_b[i]) if (i < got_b.size() && got_b[i] !== exp_b[i]) n++;
    checks++;
    if (n) begin errors++; $display("FAIL oversize_stream got %0d bytes want %0d (%0d diffs)", got_b.size(), exp_b.size(), n); end
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 2'b01) begin errors++; $display("FAIL oversize_done got %p want crc=0 len=1", got_d); end
    checks++;
    if (error_count !== CNT_W'(ec)) begin errors++; $display("FAIL oversize_errcount got %0d want %0d", error_count, ec); end
  endtask

  task automatic test_mid_reset();
    bq_t p;
    send(8'h31, 0); send(8'h32, 0); send(8'h33, 0);
    reset = 0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_last, frame_done, crc_error, len_error, frame_count, error_count} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got %h want 0", {out_valid, out_data, out_last, frame_done, frame_count, error_count});
    end
    @(posedge clk); @(posedge clk); #1 reset = 1;
    fc = 0; ec = 0;
    clear_q();
    p = '{8'h01};
    expect_frame(p, 8'h07);
    send_frame(p, 8'h07);
    idle(3);
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 2'b00) begin errors++; $display("FAIL mid_reset_done got %p want one clean", got_d); end
    checks++;
    if (got_b.size() != 1 || got_b[0] !== 9'h101) begin errors++; $display("FAIL mid_reset_stream got %p want %p", got_b, exp_b); end
    checks++;
    if (frame_count !== 1 || error_count !== 0) begin
      errors++; $display("FAIL mid_reset_counts got %0d/%0d want 1/0", frame_count, error_count);
    end
  endtask

  task automatic test_random();
    bq_t p;
    logic [7:0] crc;
    int n;
    clear_q();
    for (int f = 0; f < 25; f++) begin
      p.delete();
      repeat ($urandom_range(0, 70)) p.push_back(8'($urandom));
      crc = crc_ref(p);
      if ($urandom_range(0, 3) == 0) crc ^= 8'(1 << $urandom_range(0, 7));
      expect_frame(p, crc);
      send_frame(p, crc);
      if ($urandom_range(0, 1)) idle($urandom_range(1, 3));
    end
    idle(3);
    n = (got_b.size() != exp_b.size()) ? 1 : 0;
    foreach (exp_b[i]) if (i < got_b.size() && got_b[i] !== exp_b[i]) n++;
    checks++;
    if (n) begin errors++; $display("FAIL random_stream got %0d bytes want %0d (%0d diffs)", got_b.size(), exp_b.size(), n); end
    n = (got_d.size() != exp_d.size()) ? 1 : 0;
    foreach (exp_d[i]) if (i < got_d.size() && got_d[i] !== exp_d[i]) n++;
    checks++;
    if (n) begin errors++; $display("FAIL random_done got %p want %p", got_d, exp_d); end
    checks++;
    if (frame_count !== CNT_W'(fc) || error_count !== CNT_W'(ec)) begin
      errors++; $display("FAIL random_counts got %0d/%0d want %0d/%0d", frame_count, error_count, fc, ec);
    end
  endtask

  initial begin
    test_reset();
    test_check_value(8'hF4);
    test_check_value(8'hF5);
    test_empty();
    test_back_to_back();
    test_oversize();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
